cereal_rx: RTL and testbench

Serial-byte receiver, the receive-side counterpart of the `cereal` transmitter. It synchronises an asynchronous 8N1 line (optionally 8E1), finds the start bit, samples each bit at mid-point and presents completed bytes on a valid/ready interface. It sits between the board serial input pin and the tweetboard capture/store logic, replacing ad-hoc counter-based sampling with framing, false-start, overrun and (optionally) parity checks.

---
 rtl/cereal_pkg.sv | 34 +++
 rtl/sync2.sv | 27 ++
 rtl/cereal_rx.sv | 215 +++++++++++++++++++++
 tb/tb_cereal_rx.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cereal_pkg.sv
// Shared definitions for the cereal serial transmitter/receiver pair.
// Optional feature macro: CEREAL_RX_PARITY_EN (even parity bit between data and stop).
package cereal_pkg;

  localparam int unsigned DATA_BITS        = 8;
  localparam int unsigned CLKS_PER_BIT_DEF = 5208;  // 50 MHz / 9600 baud

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_t;

`ifdef CEREAL_RX_PARITY_EN
  localparam parity_mode_t PARITY_MODE = PAR_EVEN;
`else
  localparam parity_mode_t PARITY_MODE = PAR_NONE;
`endif

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_t;

  // Even-parity bit for a data byte (XOR of all bits).
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous input; reset value selectable.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // Metastability filter: two back-to-back flops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/cereal_rx.sv
// Serial byte receiver (8N1, or 8E1 when CEREAL_RX_PARITY_EN is defined).
// Mid-bit sampling from a down-counting baud counter, valid/ready holding register,
// frame-error, overrun and parity-error pulses.
module cereal_rx
  import cereal_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 serialIn,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int unsigned CW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned BCW = $clog2(DATA_BITS);
  localparam logic [CW-1:0]  HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);

  logic                 w_rxs;
  logic                 w_tick;
  logic                 w_deliver;

  rx_state_t            r_state,   w_state_n;
  logic [CW-1:0]        r_cnt,     w_cnt_n;
  logic [BCW-1:0]       r_bitcnt,  w_bitcnt_n;
  logic [DATA_BITS-1:0] r_shreg,   w_shreg_n;
  logic [DATA_BITS-1:0] r_data,    w_data_n;
  logic                 r_valid,   w_valid_n;
  logic                 r_busy,    w_busy_n;
  logic                 r_frame_err, w_frame_err_n;
  logic                 r_overrun, w_overrun_n;
`ifdef CEREAL_RX_PARITY_EN
  logic                 r_par_flag, w_par_flag_n;
  logic                 r_parity_err, w_parity_err_n;
`endif

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .i_clk (sysclk),
    .i_rst (reset),
    .i_d   (serialIn),
    .o_q   (w_rxs)
  );

  assign w_tick = (r_cnt == '0);

  // State and datapath registers.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bitcnt    <= '0;
      r_shreg     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef CEREAL_RX_PARITY_EN
      r_par_flag   <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_bitcnt    <= w_bitcnt_n;
      r_shreg     <= w_shreg_n;
      r_data      <= w_data_n;
      r_valid     <= w_valid_n;
      r_busy      <= w_busy_n;
      r_frame_err <= w_frame_err_n;
      r_overrun   <= w_overrun_n;
`ifdef CEREAL_RX_PARITY_EN
      r_par_flag   <= w_par_flag_n;
      r_parity_err <= w_parity_err_n;
`endif
    end
  end

  // Frame FSM, baud counter, shift register and holding-register handshake.
  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_bitcnt_n    = r_bitcnt;
    w_shreg_n     = r_shreg;
    w_data_n      = r_data;
    w_valid_n     = r_valid;
    w_frame_err_n = 1'b0;
    w_overrun_n   = 1'b0;
    w_deliver     = 1'b0;
`ifdef CEREAL_RX_PARITY_EN
    w_par_flag_n   = r_par_flag;
    w_parity_err_n = 1'b0;
`endif

    case (r_state)
      ST_IDLE: begin
        if (!w_rxs) begin
          w_bitcnt_n = '0;
          w_cnt_n    = HALF_LOAD;
          w_state_n  = ST_START;
`ifdef CEREAL_RX_PARITY_EN
          w_par_flag_n = 1'b0;
`endif
        end
      end

      ST_START: begin
        if (w_tick) begin
          if (w_rxs) begin
            w_state_n = ST_IDLE;  // false start, silently ignored
          end else begin
            w_cnt_n   = FULL_LOAD;
            w_state_n = ST_DATA;
          end
        end else begin
          w_cnt_n = r_cnt - CW'(1);
        end
      end

      ST_DATA: begin
        if (w_tick) begin
          w_shreg_n = {w_rxs, r_shreg[DATA_BITS-1:1]};
          w_cnt_n   = FULL_LOAD;
          if (r_bitcnt == LAST_BIT) begin
`ifdef CEREAL_RX_PARITY_EN
            w_state_n = ST_PARITY;
`else
            w_state_n = ST_STOP;
`endif
          end else begin
            w_bitcnt_n = r_bitcnt + BCW'(1);
          end
        end else begin
          w_cnt_n = r_cnt - CW'(1);
        end
      end

      ST_PARITY: begin
`ifdef CEREAL_RX_PARITY_EN
        if (w_tick) begin
          if (even_parity(r_shreg) ^ w_rxs) w_par_flag_n = 1'b1;
          w_cnt_n   = FULL_LOAD;
          w_state_n = ST_STOP;
        end else begin
          w_cnt_n = r_cnt - CW'(1);
        end
`else
        w_state_n = ST_IDLE;
`endif
      end

      ST_STOP: begin
        if (w_tick) begin
          if (w_rxs) begin
            w_state_n = ST_IDLE;
`ifdef CEREAL_RX_PARITY_EN
            if (r_par_flag) w_parity_err_n = 1'b1;
            else            w_deliver      = 1'b1;
`else
            w_deliver = 1'b1;
`endif
          end else begin
            w_frame_err_n = 1'b1;  // includes break: wait for line release
            w_state_n     = ST_WAIT_HIGH;
          end
        end else begin
          w_cnt_n = r_cnt - CW'(1);
        end
      end

      ST_WAIT_HIGH: begin
        if (w_rxs) w_state_n = ST_IDLE;
      end

      default: begin
        w_state_n = ST_IDLE;
      end
    endcase

    // A simultaneous accept frees the holding register for the new byte.
    if (w_deliver) begin
      if (!r_valid || rx_ready) begin
        w_data_n  = r_shreg;
        w_valid_n = 1'b1;
      end else begin
        w_overrun_n = 1'b1;
      end
    end else if (r_valid && rx_ready) begin
      w_valid_n = 1'b0;
    end

    w_busy_n = (w_state_n == ST_START) || (w_state_n == ST_DATA) ||
               (w_state_n == ST_PARITY) || (w_state_n == ST_STOP);
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign rx_busy   = r_busy;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
`ifdef CEREAL_RX_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_cereal_rx.sv
// Bench for cereal_rx: frame-level reference model (event schedule + holding
// register), per-cycle compare, directed cases and a randomized phase.
module tb_cereal_rx;

  localparam int CPB = 16;
`ifdef CEREAL_RX_PARITY_EN
  localparam int NB    = 11;
  localparam int S_LIT = 171;
`else
  localparam int NB    = 10;
  localparam int S_LIT = 155;
`endif
  // Stop-bit sample edge relative to the edge after which the start bit is driven.
  localparam int S_OFF = 3 + CPB / 2 + (NB - 1) * CPB;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       serialIn;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  cereal_rx #(.CLKS_PER_BIT(CPB)) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .serialIn   (serialIn),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // kind: 0 = no outcome (false start / aborted), 1 = good byte, 2 = frame error, 3 = parity error
  typedef struct {
    int         b;
    int         s;
    int         kind;
    logic [7:0] d;
  } ev_t;
  ev_t evq[$];

  int ready_mode = 2;  // 0 random, 1 held low, 2 held high

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge sysclk);
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge sysclk);
      #1;
    end
  endtask

  // Drives one frame; called at posedge+1, returns at posedge+1 right after the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip,
                            input int extra_low);
    logic [NB-1:0] bits;
    ev_t e;
    bits      = '0;
    bits[8:1] = b;
`ifdef CEREAL_RX_PARITY_EN
    bits[9]   = (^b) ^ par_flip;
    e.kind    = !stop_bit ? 2 : (par_flip ? 3 : 1);
`else
    e.kind    = !stop_bit ? 2 : 1;
`endif
    bits[NB-1] = stop_bit;
    e.b = cyc + 3;
    e.s = cyc + S_OFF;
    e.d = b;
    evq.push_back(e);
    for (int i = 0; i < NB; i++) begin
      serialIn = bits[i];
      repeat (CPB) @(posedge sysclk);
      #1;
    end
    if (!stop_bit) begin
      idle(extra_low);
      serialIn = 1'b1;
    end
  endtask

  // Low pulse too short to survive the mid-start-bit resample.
  task automatic glitch(input int len);
    ev_t e;
    e.b = cyc + 3;
    e.s = cyc + 3 + CPB / 2;
    e.kind = 0;
    e.d = 8'h00;
    evq.push_back(e);
    serialIn = 1'b0;
    idle(len);
    serialIn = 1'b1;
    idle(CPB - len);
  endtask

  // Consumer handshake driver.
  initial begin
    rx_ready = 1'b0;
    forever begin
      @(posedge sysclk);
      #1;
      case (ready_mode)
        0:       rx_ready = ($urandom % 3) != 0;
        1:       rx_ready = 1'b0;
        default: rx_ready = 1'b1;
      endcase
    end
  end

  // Reference model and per-cycle compare.
  initial begin
    logic       rdy_prev;
    logic       m_valid;
    logic [7:0] m_data;
    logic       eb;
    logic       good;
    logic       m_ovr;
    logic [7:0] d;
    int         k;
    rdy_prev = 1'b0;
    m_valid  = 1'b0;
    m_data   = 8'h00;
    forever begin
      @(negedge sysclk);
      if (reset) begin
        evq.delete();
        m_valid = 1'b0;
        m_data  = 8'h00;
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_busy", 32'(rx_busy), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_parity_err", 32'(parity_err), 32'd0);
      end else begin
        k  = 0;
        d  = 8'h00;
        eb = 1'b0;
        if (evq.size() > 0) begin
          eb = (cyc >= evq[0].b) && (cyc < evq[0].s);
          if (evq[0].s == cyc) begin
            k = evq[0].kind;
            d = evq[0].d;
            void'(evq.pop_front());
          end
        end
        good  = (k == 1);
        m_ovr = good && m_valid && !rdy_prev;
        if (good && (!m_valid || rdy_prev)) begin
          m_valid = 1'b1;
          m_data  = d;
        end else if (m_valid && rdy_prev) begin
          m_valid = 1'b0;
        end
        chk("rx_valid", 32'(rx_valid), 32'(m_valid));
        chk("rx_data", 32'(rx_data), 32'(m_data));
        chk("rx_busy", 32'(rx_busy), 32'(eb));
        chk("frame_err", 32'(frame_err), 32'(k == 2));
        chk("parity_err", 32'(parity_err), 32'(k == 3));
        chk("overrun", 32'(overrun), 32'(m_ovr));
      end
      rdy_prev = rx_ready;
    end
  end

  // Watchdog.
  initial begin
    #1_000_000;
    $display("FAIL watchdog at cycle %0d: run did not complete, got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end

  // Directed cases, then randomized traffic.
  initial begin
    int         e0;
    int         sel;
    int         el;
    logic [7:0] rb;
    logic       rstop;
    logic       rpf;
    logic [7:0] v;

    reset    = 1'b1;
    serialIn = 1'b1;
    idle(4);
    reset = 1'b0;
    idle(3);
    chk("post_reset_valid", 32'(rx_valid), 32'd0);
    chk("post_reset_busy", 32'(rx_busy), 32'd0);

    // 0x41 with consumer always ready: latency and delivery cycle pinned by hand.
    ready_mode = 2;
    idle(2);
    e0 = cyc;
    fork
      send_frame(8'h41, 1'b1, 1'b0, 0);
      begin
        wait_cyc(e0 + 2);
        chk("lit_busy_before", 32'(rx_busy), 32'd0);
        wait_cyc(e0 + 3);
        chk("lit_busy_at3", 32'(rx_busy), 32'd1);
        wait_cyc(e0 + S_LIT - 1);
        chk("lit_valid_pre", 32'(rx_valid), 32'd0);
        wait_cyc(e0 + S_LIT);
        chk("lit_valid_41", 32'(rx_valid), 32'd1);
        chk("lit_data_41", 32'(rx_data), 32'h41);
        chk("lit_frame_err_41", 32'(frame_err), 32'd0);
        wait_cyc(e0 + S_LIT + 1);
        chk("lit_valid_drop_41", 32'(rx_valid), 32'd0);
      end
    join
    idle(5);

    // Short glitch on idle line.
    e0 = cyc;
    fork
      glitch(4);
      begin
        wait_cyc(e0 + 4);
        chk("lit_glitch_busy", 32'(rx_busy), 32'd1);
        wait_cyc(e0 + 12);
        chk("lit_glitch_idle", 32'(rx_busy), 32'd0);
        chk("lit_glitch_valid", 32'(rx_valid), 32'd0);
      end
    join
    idle(5);

    // Break: 0x55 with stop low and line held low, then 0x0D.
    e0 = cyc;
    fork
      send_frame(8'h55, 1'b0, 1'b0, 40);
      begin
        wait_cyc(e0 + S_LIT);
        chk("lit_frame_err_55", 32'(frame_err), 32'd1);
        chk("lit_valid_55", 32'(rx_valid), 32'd0);
      end
    join
    idle(2);
    e0 = cyc;
    send_frame(8'h0D, 1'b1, 1'b0, 0);
    wait_cyc(e0 + S_LIT);
    chk("lit_data_0d", 32'(rx_data), 32'h0D);
    idle(5);

    // Overrun: consumer stalled, two frames back-to-back.
    ready_mode = 1;
    idle(3);
    send_frame(8'h31, 1'b1, 1'b0, 0);
    e0 = cyc;
    fork
      send_frame(8'h32, 1'b1, 1'b0, 0);
      begin
        wait_cyc(e0 + S_LIT);
        chk("lit_overrun_32", 32'(overrun), 32'd1);
        chk("lit_held_31", 32'(rx_data), 32'h31);
      end
    join
    idle(3);
    chk("lit_still_valid_31", 32'(rx_valid), 32'd1);
    ready_mode = 2;
    idle(4);
    chk("lit_accepted_31", 32'(rx_valid), 32'd0);
    chk("lit_data_kept_31", 32'(rx_data), 32'h31);

    // Reset in the middle of data bit 4 of 0x7E, then 0xA5.
    v  = 8'h7E;
    e0 = cyc;
    begin
      ev_t e;
      e.b = e0 + 3;
      e.s = e0 + S_OFF;
      e.kind = 0;
      e.d = 8'h00;
      evq.push_back(e);
    end
    serialIn = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      serialIn = v[i];
      idle(CPB);
    end
    serialIn = v[4];
    idle(CPB / 2);
    reset    = 1'b1;
    serialIn = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(5);
    chk("lit_busy_after_abort", 32'(rx_busy), 32'd0);
    e0 = cyc;
    send_frame(8'hA5, 1'b1, 1'b0, 0);
    wait_cyc(e0 + S_LIT);
    chk("lit_data_a5", 32'(rx_data), 32'hA5);
    idle(5);

`ifdef CEREAL_RX_PARITY_EN
    // 0x03 has even data parity, so parity bit 1 is wrong and 0 is right.
    e0 = cyc;
    send_frame(8'h03, 1'b1, 1'b1, 0);
    wait_cyc(e0 + S_LIT);
    chk("lit_parity_err_03", 32'(parity_err), 32'd1);
    chk("lit_parity_valid_03", 32'(rx_valid), 32'd0);
    idle(3);
    e0 = cyc;
    send_frame(8'h03, 1'b1, 1'b0, 0);
    wait_cyc(e0 + S_LIT);
    chk("lit_parity_ok_03", 32'(rx_data), 32'h03);
    chk("lit_parity_ok_valid", 32'(rx_valid), 32'd1);
    idle(3);
`endif

    // Randomized traffic with random consumer back-pressure.
    ready_mode = 0;
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom % 10);
      if (sel == 0) begin
        glitch(1 + int'($urandom % 6));
        idle(int'($urandom % 4));
      end else begin
        rb    = 8'($urandom);
        rstop = (sel != 1);
        rpf   = (sel == 2);
        el    = int'($urandom % 30);
        send_frame(rb, rstop, rpf, el);
        if (rstop) idle(int'($urandom % 4));
        else       idle(2 + int'($urandom % 4));
      end
    end

    ready_mode = 2;
    idle(CPB * 2);
    chk("events_drained", 32'(evq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
